// File: rtl/dmi_host_bridge_if.sv
// rtl/dmi_host_bridge_if.sv - host byte streams, DMI access and core control bundle
//
// Signal groups:
//   rx_*      command byte stream, host -> bridge (tdata/tvalid/tready)
//   tx_*      response byte stream, bridge -> host (tdata/tvalid/tready)
//   dm_*      DMI register access towards the DebugModule
//   enter_debug/req_halt/req_resume/step   one-cycle control pulses to the DMI
//   halted/running/stalled                 core state reported by the DMI
// Modports: master = bridge side, slave = host shim + DebugModule side.
interface dmi_host_bridge_if;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        dm_write;
    logic [6:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_access_valid;
    logic        enter_debug;
    logic        req_halt;
    logic        req_resume;
    logic        step;
    logic        halted;
    logic        running;
    logic        stalled;

    modport master (
        input  rx_tdata, rx_tvalid, tx_tready, dm_rdata, dm_access_valid,
        input  halted, running, stalled,
        output rx_tready, tx_tdata, tx_tvalid, dm_write, dm_addr, dm_wdata,
        output enter_debug, req_halt, req_resume, step
    );

    modport slave (
        output rx_tdata, rx_tvalid, tx_tready, dm_rdata, dm_access_valid,
        output halted, running, stalled,
        input  rx_tready, tx_tdata, tx_tvalid, dm_write, dm_addr, dm_wdata,
        input  enter_debug, req_halt, req_resume, step
    );
endinterface

// File: rtl/dmi_host_bridge.sv
// rtl/dmi_host_bridge.sv - byte-framed host command bridge driving the debug module interface
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   dmi_host_bridge_if.master: rx/tx byte streams, DMI access, control pulses, core state
// Frames: 01 addr -> 4 rdata bytes (LE) | 02 addr d0..d3 -> ACK | 03 halt | 04 resume
//         05 step | 06 status | 07 enter_debug | other opcodes -> NAK
module dmi_host_bridge #(
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [7:0]  ACK     = 8'hA5,
    parameter logic [7:0]  NAK     = 8'hEE
) (
    input logic               clk,
    input logic               rst,
    dmi_host_bridge_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, DMI_ACC, WAIT_CORE, SEND} state_t;

    state_t        state;
    logic          is_write;
    logic          wait_running;   // WAIT_CORE target: 0 = halted, 1 = running
    logic [6:0]    addr_q;         // write address parked until the data bytes are in
    logic [1:0]    byte_cnt;
    logic [TW-1:0] timer;
    logic [31:0]   resp_q;         // response bytes, current byte in [7:0]
    logic [1:0]    tx_left;        // bytes still to send after the current one
    logic          rx_fire;
    logic          tx_fire;
    logic          core_ok;

    assign rx_fire     = bus.rx_tvalid & bus.rx_tready;
    assign tx_fire     = bus.tx_tvalid & bus.tx_tready;
    assign core_ok     = wait_running ? bus.running : bus.halted;
    assign bus.tx_tdata = resp_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            is_write        <= 1'b0;
            wait_running    <= 1'b0;
            addr_q          <= '0;
            byte_cnt        <= '0;
            timer           <= '0;
            resp_q          <= '0;
            tx_left         <= '0;
            bus.rx_tready   <= 1'b0;
            bus.tx_tvalid   <= 1'b0;
            bus.dm_write    <= 1'b0;
            bus.dm_addr     <= '0;
            bus.dm_wdata    <= '0;
            bus.enter_debug <= 1'b0;
            bus.req_halt    <= 1'b0;
            bus.req_resume  <= 1'b0;
            bus.step        <= 1'b0;
        end else begin
            // Control outputs are single-cycle pulses; only the opcode accept sets one.
            bus.enter_debug <= 1'b0;
            bus.req_halt    <= 1'b0;
            bus.req_resume  <= 1'b0;
            bus.step        <= 1'b0;

            case (state)
                IDLE: begin
                    bus.rx_tready <= 1'b1;
                    if (rx_fire) begin
                        timer <= '0;
                        case (bus.rx_tdata)
                            8'h01, 8'h02: begin
                                is_write <= (bus.rx_tdata == 8'h02);
                                state    <= GET_ADDR;
                            end
                            8'h03, 8'h04: begin
                                bus.req_halt   <= (bus.rx_tdata == 8'h03);
                                bus.req_resume <= (bus.rx_tdata == 8'h04);
                                wait_running   <= (bus.rx_tdata == 8'h04);
                                bus.rx_tready  <= 1'b0;
                                state          <= WAIT_CORE;
                            end
                            8'h05, 8'h07: begin
                                bus.step        <= (bus.rx_tdata == 8'h05);
                                bus.enter_debug <= (bus.rx_tdata == 8'h07);
                                resp_q          <= {24'h0, ACK};
                                tx_left         <= 2'd0;
                                bus.tx_tvalid   <= 1'b1;
                                bus.rx_tready   <= 1'b0;
                                state           <= SEND;
                            end
                            8'h06: begin
                                resp_q        <= {29'h0, bus.stalled, bus.running, bus.halted};
                                tx_left       <= 2'd0;
                                bus.tx_tvalid <= 1'b1;
                                bus.rx_tready <= 1'b0;
                                state         <= SEND;
                            end
                            default: begin
                                resp_q        <= {24'h0, NAK};
                                tx_left       <= 2'd0;
                                bus.tx_tvalid <= 1'b1;
                                bus.rx_tready <= 1'b0;
                                state         <= SEND;
                            end
                        endcase
                    end
                end

                GET_ADDR: begin
                    if (rx_fire) begin
                        if (is_write) begin
                            addr_q   <= bus.rx_tdata[6:0];
                            byte_cnt <= 2'd0;
                            state    <= GET_DATA;
                        end else begin
                            bus.dm_addr   <= bus.rx_tdata[6:0];
                            bus.rx_tready <= 1'b0;
                            state         <= DMI_ACC;
                        end
                    end
                end

                GET_DATA: begin
                    if (rx_fire) begin
                        bus.dm_wdata[8*byte_cnt +: 8] <= bus.rx_tdata;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.dm_addr   <= addr_q;
                            bus.dm_write  <= 1'b1;
                            bus.rx_tready <= 1'b0;
                            state         <= DMI_ACC;
                        end
                    end
                end

                DMI_ACC: begin
                    timer <= timer + 1'b1;
                    // A completion in the final timer cycle still counts as success.
                    if (bus.dm_access_valid) begin
                        bus.dm_write  <= 1'b0;
                        bus.tx_tvalid <= 1'b1;
                        state         <= SEND;
                        if (is_write) begin
                            resp_q  <= {24'h0, ACK};
                            tx_left <= 2'd0;
                        end else begin
                            resp_q  <= bus.dm_rdata;
                            tx_left <= 2'd3;
                        end
                    end else if (timer == TIMER_LAST) begin
                        bus.dm_write  <= 1'b0;
                        resp_q        <= {24'h0, NAK};
                        tx_left       <= 2'd0;
                        bus.tx_tvalid <= 1'b1;
                        state         <= SEND;
                    end
                end

                WAIT_CORE: begin
                    timer <= timer + 1'b1;
                    if (core_ok || timer == TIMER_LAST) begin
                        resp_q        <= {24'h0, core_ok ? ACK : NAK};
                        tx_left       <= 2'd0;
                        bus.tx_tvalid <= 1'b1;
                        state         <= SEND;
                    end
                end

                SEND: begin
                    if (tx_fire) begin
                        if (tx_left == 2'd0) begin
                            bus.tx_tvalid <= 1'b0;
                            bus.rx_tready <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            resp_q  <= {8'h0, resp_q[31:8]};
                            tx_left <= tx_left - 2'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
